alu_multicycle: RTL and testbench

// - Multi-cycle ALU that sits directly downstream of the general-purpose register file.
// - Operands:
//   - operand_a comes from the register file's accumulator output.
//   - operand_b comes from its X/Y data_out.
// - Single-cycle ops finish in 1 cycle. MUL is shift-add and DIV/MOD are restoring; these take WIDTH cycles.
// - result/save_acc feed the register file's data_in_acc_alu / signal_save_after_alu inputs.

---
 rtl/alu_multicycle.sv | 245 ++++++++++++++++++++++++
 tb/tb_alu_multicycle.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle.sv
// alu_multicycle: multi-cycle ALU fed by the register file accumulator (operand_a)
// and X/Y data_out (operand_b).
// - Single-cycle ops finish in one cycle.
// - MUL is a shift-add multiplier that takes WIDTH EXEC cycles.
// - DIV/MOD use a restoring divider that takes WIDTH EXEC cycles. It exists only
//   when the macro ALU_DIV_EN is defined; otherwise opcodes 9/A are treated as illegal.
// - result/save_acc drive the register file's data_in_acc_alu / signal_save_after_alu.
module alu_multicycle #(
    parameter int WIDTH    = 16,
    parameter int OPCODE_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [WIDTH-1:0]    operand_a,
    input  logic [WIDTH-1:0]    operand_b,
    output logic                busy,
    output logic                done,
    output logic                save_acc,
    output logic [WIDTH-1:0]    result,
    output logic [3:0]          flags,
    output logic                illegal_op
);

    localparam int MSB   = WIDTH - 1;
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(4'h0);
    localparam logic [OPCODE_W-1:0] OP_SUB = OPCODE_W'(4'h1);
    localparam logic [OPCODE_W-1:0] OP_AND = OPCODE_W'(4'h2);
    localparam logic [OPCODE_W-1:0] OP_OR  = OPCODE_W'(4'h3);
    localparam logic [OPCODE_W-1:0] OP_XOR = OPCODE_W'(4'h4);
    localparam logic [OPCODE_W-1:0] OP_NOT = OPCODE_W'(4'h5);
    localparam logic [OPCODE_W-1:0] OP_SHL = OPCODE_W'(4'h6);
    localparam logic [OPCODE_W-1:0] OP_SHR = OPCODE_W'(4'h7);
    localparam logic [OPCODE_W-1:0] OP_MUL = OPCODE_W'(4'h8);
    localparam logic [OPCODE_W-1:0] OP_DIV = OPCODE_W'(4'h9);
    localparam logic [OPCODE_W-1:0] OP_MOD = OPCODE_W'(4'hA);
    localparam logic [OPCODE_W-1:0] OP_CMP = OPCODE_W'(4'hB);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;
    typedef enum logic [1:0] {IT_MUL, IT_DIV, IT_MOD} iter_t;

    state_t             state_q, state_d;
    iter_t              iter_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   hi_q;   // MUL: upper partial product; DIV/MOD: remainder
    logic [WIDTH-1:0]   lo_q;   // MUL: multiplier/low product; DIV/MOD: dividend/quotient

    // Single-cycle decode and compute, taken straight from the ports at start
    logic [WIDTH:0]     add_w, sub_w;
    logic               add_v, sub_v;
    logic [WIDTH-1:0]   sc_res;
    logic               sc_c, sc_v, sc_save, sc_illegal, sc_iter;
    logic [3:0]         sc_flags;

    // Iteration step for the multi-cycle ops
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   mul_hi_d, mul_lo_d;
    logic [WIDTH-1:0]   div_rem_d, div_quo_d;
    logic [WIDTH-1:0]   step_hi, step_lo, it_res;
    logic               it_c;

    assign add_w = {1'b0, operand_a} + {1'b0, operand_b};
    assign sub_w = {1'b0, operand_a} - {1'b0, operand_b};
    assign add_v = (operand_a[MSB] == operand_b[MSB]) && (add_w[MSB] != operand_a[MSB]);
    assign sub_v = (operand_a[MSB] != operand_b[MSB]) && (sub_w[MSB] != operand_a[MSB]);

    assign busy = (state_q != S_IDLE);

    // Decode the launched opcode: single-cycle value/flags or hand-off to EXEC
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        sc_res     = '0;
        sc_c       = 1'b0;
        sc_v       = 1'b0;
        sc_save    = 1'b1;
        sc_illegal = 1'b0;
        sc_iter    = 1'b0;
        case (opcode)
            OP_ADD: begin
                sc_res = add_w[MSB:0];
                sc_c   = add_w[WIDTH];
                sc_v   = add_v;
            end
            OP_SUB: begin
                sc_res = sub_w[MSB:0];
                sc_c   = sub_w[WIDTH];
                sc_v   = sub_v;
            end
            OP_AND: sc_res = operand_a & operand_b;
            OP_OR:  sc_res = operand_a | operand_b;
            OP_XOR: sc_res = operand_a ^ operand_b;
            OP_NOT: sc_res = ~operand_a;
            OP_SHL: begin
                sc_res = {operand_a[MSB-1:0], 1'b0};
                sc_c   = operand_a[MSB];
            end
            OP_SHR: begin
                sc_res = {1'b0, operand_a[MSB:1]};
                sc_c   = operand_a[0];
            end
            OP_MUL: sc_iter = 1'b1;
            OP_CMP: begin
                // Difference only feeds the flags; result is left alone.
                sc_res  = sub_w[MSB:0];
                sc_c    = sub_w[WIDTH];
                sc_v    = sub_v;
                sc_save = 1'b0;
            end
`ifdef ALU_DIV_EN
            OP_DIV: begin
                if (operand_b == '0) begin
                    sc_res = '1;
                    sc_v   = 1'b1;
                end else begin
                    sc_iter = 1'b1;
                end
            end
            OP_MOD: begin
                if (operand_b == '0) begin
                    sc_res = operand_a;
                    sc_v   = 1'b1;
                end else begin
                    sc_iter = 1'b1;
                end
            end
`endif
            default: begin
                sc_illegal = 1'b1;
                sc_save    = 1'b0;
            end
        endcase
        sc_flags = {(sc_res == '0), sc_res[MSB], sc_c, sc_v};
    end

    // Shift-add multiplier step: add multiplicand when the current multiplier bit is set, shift right
    always_comb begin
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        mul_hi_d = mul_sum[WIDTH:1];
        mul_lo_d = {mul_sum[0], lo_q[MSB:1]};
    end

`ifdef ALU_DIV_EN
    logic [WIDTH:0] div_shift, div_diff;

    // Restoring divider step: shift in the next dividend bit, subtract if it fits
    always_comb begin
        div_shift = {hi_q, lo_q[MSB]};
        div_diff  = div_shift - {1'b0, b_q};
        div_rem_d = div_diff[WIDTH] ? div_shift[MSB:0] : div_diff[MSB:0];
        div_quo_d = {lo_q[MSB-1:0], ~div_diff[WIDTH]};
    end
`else
    assign div_rem_d = '0;
    assign div_quo_d = '0;
`endif

    // Select the active iterative op's next state and its final value
    always_comb begin
        step_hi = mul_hi_d;
        step_lo = mul_lo_d;
        it_res  = mul_lo_d;
        it_c    = (mul_hi_d != '0);
        if (iter_q != IT_MUL) begin
            step_hi = div_rem_d;
            step_lo = div_quo_d;
            it_res  = (iter_q == IT_DIV) ? div_quo_d : div_rem_d;
            it_c    = 1'b0;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // FSM next-state: IDLE launches, EXEC iterates until the counter hits zero, DONE lasts one cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = sc_iter ? S_EXEC : S_DONE;
            S_EXEC: if (cnt_q == '0) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: capture operands, iterate, and register result/flags/pulses on entry to DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            iter_q     <= IT_MUL;
            cnt_q      <= '0;
            b_q        <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            result     <= '0;
            flags      <= '0;
            done       <= 1'b0;
            save_acc   <= 1'b0;
            illegal_op <= 1'b0;
        end else begin
            done       <= 1'b0;
            save_acc   <= 1'b0;
            illegal_op <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (sc_iter) begin
                            iter_q <= (opcode == OP_DIV) ? IT_DIV :
                                      (opcode == OP_MOD) ? IT_MOD : IT_MUL;
                            cnt_q  <= CNT_W'(WIDTH - 1);
                            b_q    <= operand_b;
                            hi_q   <= '0;
                            lo_q   <= operand_a;
                        end else begin
                            done       <= 1'b1;
                            save_acc   <= sc_save;
                            illegal_op <= sc_illegal;
                            if (sc_save)     result <= sc_res;
                            if (!sc_illegal) flags  <= sc_flags;
                        end
                    end
                end
                S_EXEC: begin
                    hi_q  <= step_hi;
                    lo_q  <= step_lo;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == '0) begin
                        done     <= 1'b1;
                        save_acc <= 1'b1;
                        result   <= it_res;
                        flags    <= {(it_res == '0), it_res[MSB], it_c, 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle: directed vectors push hand-computed
// expectations, a monitor pops and compares on every done pulse.
module tb_alu_multicycle;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  opcode;
    logic [15:0] operand_a, operand_b;
    logic        busy, done, save_acc, illegal_op;
    logic [15:0] result;
    logic [3:0]  flags;

    typedef struct {
        string       name;
        logic [15:0] res;
        logic [3:0]  flg;
        logic        sv;
        logic        il;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    alu_multicycle #(.WIDTH(16), .OPCODE_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode),
        .operand_a(operand_a), .operand_b(operand_b),
        .busy(busy), .done(done), .save_acc(save_acc), .result(result),
        .flags(flags), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_result"}, result, e.res);
                check({e.name, "_flags"}, flags, e.flg);
                check({e.name, "_save_acc"}, save_acc, e.sv);
                check({e.name, "_illegal"}, illegal_op, e.il);
                check({e.name, "_latency"}, cyc, e.cyc);
                check({e.name, "_busy"}, busy, 1);
            end
        end
    end

    task automatic issue(input string name, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] res, input logic [3:0] flg,
                         input logic sv, input logic il, input int lat);
        exp_t e;
        @(negedge clk);
        start = 1'b1; opcode = op; operand_a = a; operand_b = b;
        e.name = name; e.res = res; e.flg = flg; e.sv = sv; e.il = il; e.cyc = cyc + lat;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            #1;
            if (sb.size() == 0 && !busy) ok = 1'b1;
        end
        if (!ok) check("wait_idle_timeout", 1, 0);
    endtask

    task automatic run(input string name, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] res, input logic [3:0] flg,
                       input logic sv, input logic il, input int lat);
        issue(name, op, a, b, res, flg, sv, il, lat);
        wait_idle();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_result"}, result, 0);
        check({tag, "_flags"}, flags, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_save_acc"}, save_acc, 0);
        check({tag, "_illegal"}, illegal_op, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "global timeout");
    end

    initial begin
        rst = 1'b1; start = 1'b0; opcode = '0; operand_a = '0; operand_b = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // flags are {Z,N,C,V}
        run("add_ovf", 4'h0, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101, 1, 0, 1);
        run("sub_zero", 4'h1, 16'h0005, 16'h0005, 16'h0000, 4'b1000, 1, 0, 1);
        run("cmp_lt", 4'hB, 16'h0003, 16'h0005, 16'h0000, 4'b0110, 0, 0, 1);

        // MUL with an ignored start and operand change mid-EXEC
        issue("mul_0100", 4'h8, 16'h0100, 16'h0100, 16'h0000, 4'b1010, 1, 0, 17);
        repeat (4) @(negedge clk);
        check("mul_busy_mid", busy, 1);
        start = 1'b1; opcode = 4'h0; operand_a = 16'hFFFF; operand_b = 16'hFFFF;
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        run("and", 4'h2, 16'h0F0F, 16'h00FF, 16'h000F, 4'b0000, 1, 0, 1);
        run("or", 4'h3, 16'hF000, 16'h000F, 16'hF00F, 4'b0100, 1, 0, 1);
        run("xor", 4'h4, 16'hAAAA, 16'hAAAA, 16'h0000, 4'b1000, 1, 0, 1);
        run("not", 4'h5, 16'h0000, 16'h1234, 16'hFFFF, 4'b0100, 1, 0, 1);
        run("shl", 4'h6, 16'h8001, 16'h0000, 16'h0002, 4'b0010, 1, 0, 1);
        run("shr", 4'h7, 16'h0003, 16'h0000, 16'h0001, 4'b0010, 1, 0, 1);
        run("sub_borrow", 4'h1, 16'h0003, 16'h0005, 16'hFFFE, 4'b0110, 1, 0, 1);
        run("add_carry", 4'h0, 16'hFFFF, 16'h0001, 16'h0000, 4'b1010, 1, 0, 1);
        run("mul_small", 4'h8, 16'h0003, 16'h0005, 16'h000F, 4'b0000, 1, 0, 17);
        run("mul_max", 4'h8, 16'hFFFF, 16'hFFFF, 16'h0001, 4'b0010, 1, 0, 17);

        // Back-to-back: start raised in the done cycle, held through the IDLE cycle
        begin
            exp_t e;
            issue("b2b_add", 4'h0, 16'h0002, 16'h0003, 16'h0005, 4'b0000, 1, 0, 1);
            start = 1'b1; opcode = 4'h1; operand_a = 16'h0009; operand_b = 16'h0002;
            e.name = "b2b_sub"; e.res = 16'h0007; e.flg = 4'b0000; e.sv = 1; e.il = 0;
            e.cyc = cyc + 2;
            sb.push_back(e);
            repeat (2) @(negedge clk);
            start = 1'b0;
            wait_idle();
        end

`ifdef ALU_DIV_EN
        run("div", 4'h9, 16'h0064, 16'h0007, 16'h000E, 4'b0000, 1, 0, 17);
        run("mod", 4'hA, 16'h0064, 16'h0007, 16'h0002, 4'b0000, 1, 0, 17);
        run("div_small", 4'h9, 16'h0007, 16'h0064, 16'h0000, 4'b1000, 1, 0, 17);
        run("mod_max", 4'hA, 16'hFFFF, 16'h0010, 16'h000F, 4'b0000, 1, 0, 17);
        run("div_by0", 4'h9, 16'h1234, 16'h0000, 16'hFFFF, 4'b0101, 1, 0, 1);
        run("mod_by0", 4'hA, 16'h1234, 16'h0000, 16'h1234, 4'b0001, 1, 0, 1);
`else
        run("pre_div", 4'h0, 16'h0001, 16'h0001, 16'h0002, 4'b0000, 1, 0, 1);
        run("div_illegal", 4'h9, 16'h0064, 16'h0007, 16'h0002, 4'b0000, 0, 1, 1);
        run("mod_illegal", 4'hA, 16'h0064, 16'h0007, 16'h0002, 4'b0000, 0, 1, 1);
`endif
        run("pre_illegal", 4'h0, 16'h0001, 16'h0001, 16'h0002, 4'b0000, 1, 0, 1);
        run("op_f_illegal", 4'hF, 16'h1111, 16'h2222, 16'h0002, 4'b0000, 0, 1, 1);

        // Reset during MUL: no expectation pushed, so any done is flagged by the monitor
        @(negedge clk);
        start = 1'b1; opcode = 4'h8; operand_a = 16'h0100; operand_b = 16'h0100;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        check("mul_abort_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("abort");
        rst = 1'b0;
        repeat (25) @(negedge clk);
        check("abort_no_done_busy", busy, 0);
        run("add_after_rst", 4'h0, 16'h0001, 16'h0001, 16'h0002, 4'b0000, 1, 0, 1);

        check("queue_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
